// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - HI/LO multiply/divide sequencer port bundle
interface muldiv_seq_if #(
   parameter int XLEN = 32
);
   logic            i_op_valid;
   logic [2:0]      i_op;
   logic            i_mthi;
   logic            i_mtlo;
   logic [XLEN-1:0] i_src_a;
   logic [XLEN-1:0] i_src_b;
   logic            i_flush;
   logic            o_stall;
   logic            o_busy;
   logic [XLEN-1:0] o_hi;
   logic [XLEN-1:0] o_lo;

   modport master (
      output i_op_valid, i_op, i_mthi, i_mtlo, i_src_a, i_src_b, i_flush,
      input  o_stall, o_busy, o_hi, o_lo
   );

   modport slave (
      input  i_op_valid, i_op, i_mthi, i_mtlo, i_src_a, i_src_b, i_flush,
      output o_stall, o_busy, o_hi, o_lo
   );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - HI/LO multiply/divide sequencer owning the HI/LO registers
module muldiv_seq #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] HILO_RST = '0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   muldiv_seq_if.slave bus
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              w_stall;
   logic              w_accept;
   logic              w_is_div;
   logic              w_signed;

   logic [1:0]        r_op_kind;   // op[2:1]: 00 plain mul, 10 madd, 11 msub
   logic [2*XLEN-1:0] r_prod;
   logic [XLEN-1:0]   r_dvd;       // dividend shifts out, quotient shifts in
   logic [XLEN-1:0]   r_dvs;
   logic [XLEN-1:0]   r_rem;
   logic [XLEN-1:0]   r_a;
   logic              r_neg_q;
   logic              r_neg_r;
   logic              r_dz;
   logic [CW-1:0]     r_cnt;
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;

   logic [2*XLEN-1:0] w_a_ext;
   logic [2*XLEN-1:0] w_b_ext;
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_hilo;
   logic [2*XLEN-1:0] w_mac;
   logic [XLEN-1:0]   w_a_abs;
   logic [XLEN-1:0]   w_b_abs;
   logic [XLEN:0]     w_rem_sh;
   logic [XLEN:0]     w_diff;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_rem;

   assign w_is_div = (bus.i_op[2:1] == 2'b01);
   assign w_signed = ~bus.i_op[0];
   assign w_accept = (r_state == S_IDLE) & bus.i_op_valid & ~bus.i_flush;

   // Sign/zero extension to 2*XLEN makes one truncated multiply serve both signednesses
   assign w_a_ext = w_signed ? {{XLEN{bus.i_src_a[XLEN-1]}}, bus.i_src_a} : {{XLEN{1'b0}}, bus.i_src_a};
   assign w_b_ext = w_signed ? {{XLEN{bus.i_src_b[XLEN-1]}}, bus.i_src_b} : {{XLEN{1'b0}}, bus.i_src_b};
   assign w_prod  = w_a_ext * w_b_ext;
   assign w_a_abs = (w_signed & bus.i_src_a[XLEN-1]) ? -bus.i_src_a : bus.i_src_a;
   assign w_b_abs = (w_signed & bus.i_src_b[XLEN-1]) ? -bus.i_src_b : bus.i_src_b;

   assign w_hilo  = {r_hi, r_lo};
   assign w_mac   = (r_op_kind == 2'b10) ? w_hilo + r_prod :
                    (r_op_kind == 2'b11) ? w_hilo - r_prod : r_prod;

   // Remainder stays below the divisor, so one extra bit is enough for the trial subtract
   assign w_rem_sh = {r_rem, r_dvd[XLEN-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_dvs};
   assign w_quo    = r_neg_q ? -r_dvd : r_dvd;
   assign w_rem    = r_neg_r ? -r_rem : r_rem;

   assign bus.o_stall = w_stall;
   assign bus.o_busy  = (r_state != S_IDLE);
   assign bus.o_hi    = r_hi;
   assign bus.o_lo    = r_lo;

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next state and combinational stall; flush overrides everything
   always_comb begin
      w_next  = r_state;
      w_stall = 1'b0;
      case (r_state)
         S_IDLE: if (w_accept) begin
            w_stall = 1'b1;
            w_next  = w_is_div ? S_DIV : S_MUL;
         end
         S_MUL:  w_next = S_IDLE;
         S_DIV: begin
            w_stall = 1'b1;
            if (r_cnt == CW'(XLEN-1)) w_next = S_DONE;
         end
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (bus.i_flush) begin
         w_stall = 1'b0;
         w_next  = S_IDLE;
      end
      if (i_rst) w_stall = 1'b0;
   end

   // Operand capture, divide iterations and HI/LO writes
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_op_kind <= '0;
         r_prod    <= '0;
         r_dvd     <= '0;
         r_dvs     <= '0;
         r_rem     <= '0;
         r_a       <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_dz      <= 1'b0;
         r_cnt     <= '0;
         r_hi      <= HILO_RST;
         r_lo      <= HILO_RST;
      end else begin
         if (w_accept) begin
            r_op_kind <= bus.i_op[2:1];
            r_prod    <= w_prod;
            r_dvd     <= w_a_abs;
            r_dvs     <= w_b_abs;
            r_rem     <= '0;
            r_a       <= bus.i_src_a;
            r_neg_q   <= w_signed & (bus.i_src_a[XLEN-1] ^ bus.i_src_b[XLEN-1]);
            r_neg_r   <= w_signed & bus.i_src_a[XLEN-1];
            r_dz      <= (bus.i_src_b == '0);
            r_cnt     <= '0;
         end
         if (!bus.i_flush) begin
            case (r_state)
               S_IDLE: if (!bus.i_op_valid) begin
                  if (bus.i_mthi) r_hi <= bus.i_src_a;
                  if (bus.i_mtlo) r_lo <= bus.i_src_a;
               end
               S_MUL: {r_hi, r_lo} <= w_mac;
               S_DIV: begin
                  r_rem <= w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
                  r_dvd <= {r_dvd[XLEN-2:0], ~w_diff[XLEN]};
                  r_cnt <= r_cnt + 1'b1;
               end
               S_DONE: begin
                  r_lo <= r_dz ? '1  : w_quo;
                  r_hi <= r_dz ? r_a : w_rem;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq against an arithmetic HI/LO model
module tb_muldiv_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   muldiv_seq_if #(.XLEN(32)) bus ();

   muldiv_seq #(.XLEN(32), .HILO_RST(32'h0)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Architectural effect of one op on HI/LO, straight from the instruction definitions
   task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      logic [63:0] acc;
      int sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      if (op == 3'd2 || op == 3'd3) begin
         if (b == 32'd0) begin
            m_lo = 32'hFFFF_FFFF;
            m_hi = a;
         end else if (op == 3'd3) begin
            m_lo = a / b;
            m_hi = a % b;
         end else if (a == 32'h8000_0000 && sb == -1) begin
            m_lo = 32'h8000_0000;
            m_hi = 32'h0;
         end else begin
            m_lo = sa / sb;
            m_hi = sa % sb;
         end
      end else begin
         if (op[0]) p = {32'h0, a} * {32'h0, b};
         else       p = longint'(sa) * longint'(sb);
         acc = {m_hi, m_lo};
         if (op == 3'd4 || op == 3'd5)      acc = acc + p;
         else if (op == 3'd6 || op == 3'd7) acc = acc - p;
         else                               acc = p;
         {m_hi, m_lo} = acc;
      end
   endtask

   // Issue one op, holding op_valid while stalled; flush_at>0 flushes in that divide iteration
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int flush_at);
      int n;
      bit is_div;
      is_div = (op == 3'd2 || op == 3'd3);
      @(negedge clk);
      bus.i_op_valid = 1'b1;
      bus.i_op = op;
      bus.i_src_a = a;
      bus.i_src_b = b;
      #1;
      chk("c0_stall", {63'd0, bus.o_stall}, 64'd1);
      n = 1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (flush_at == i) bus.i_flush = 1'b1;
         #1;
         if (!bus.o_stall) break;
         n++;
      end
      chk("stall_cycles", 64'(n), (flush_at > 0) ? 64'(flush_at) : (is_div ? 64'd33 : 64'd1));
      chk("hilo_before_write", {bus.o_hi, bus.o_lo}, {m_hi, m_lo});
      chk("busy_in_final", {63'd0, bus.o_busy}, 64'd1);
      @(negedge clk);
      bus.i_op_valid = 1'b0;
      bus.i_flush = 1'b0;
      #1;
      if (flush_at == 0) model_op(op, a, b);
      chk("hi", {32'd0, bus.o_hi}, {32'd0, m_hi});
      chk("lo", {32'd0, bus.o_lo}, {32'd0, m_lo});
      chk("busy_after", {63'd0, bus.o_busy}, 64'd0);
      chk("stall_after", {63'd0, bus.o_stall}, 64'd0);
   endtask

   task automatic mt(input bit to_hi, input logic [31:0] v);
      @(negedge clk);
      bus.i_mthi = to_hi;
      bus.i_mtlo = !to_hi;
      bus.i_src_a = v;
      #1;
      chk("mt_stall", {63'd0, bus.o_stall}, 64'd0);
      @(negedge clk);
      bus.i_mthi = 1'b0;
      bus.i_mtlo = 1'b0;
      #1;
      if (to_hi) m_hi = v;
      else       m_lo = v;
      chk("mt_hilo", {bus.o_hi, bus.o_lo}, {m_hi, m_lo});
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      bus.i_op_valid = 1'b0;
      bus.i_op = 3'd0;
      bus.i_mthi = 1'b0;
      bus.i_mtlo = 1'b0;
      bus.i_src_a = '0;
      bus.i_src_b = '0;
      bus.i_flush = 1'b0;
      #1;
      chk("rst_hilo", {bus.o_hi, bus.o_lo}, 64'd0);
      chk("rst_stall_busy", {62'd0, bus.o_stall, bus.o_busy}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 0);
      chk("div_7_m2", {bus.o_hi, bus.o_lo}, {32'h1, 32'hFFFF_FFFD});
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      chk("multu_max", {bus.o_hi, bus.o_lo}, {32'hFFFF_FFFE, 32'h1});
      mt(1'b0, 32'd5);
      mt(1'b1, 32'd0);
      run_op(3'd4, 32'hFFFF_FFFF, 32'd3, 0);
      chk("madd", {bus.o_hi, bus.o_lo}, {32'h0, 32'h2});
      run_op(3'd6, 32'hFFFF_FFFF, 32'd3, 0);
      chk("msub", {bus.o_hi, bus.o_lo}, {32'h0, 32'h5});
      run_op(3'd3, 32'h1234, 32'd0, 0);
      chk("divu_by_zero", {bus.o_hi, bus.o_lo}, {32'h1234, 32'hFFFF_FFFF});
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      chk("div_overflow", {bus.o_hi, bus.o_lo}, {32'h0, 32'h8000_0000});
      run_op(3'd3, 32'd100, 32'd7, 10);
      run_op(3'd0, 32'hFFFF_FFF0, 32'd9, 0);

      // op_valid together with flush in IDLE must not start anything
      @(negedge clk);
      bus.i_op_valid = 1'b1;
      bus.i_op = 3'd2;
      bus.i_flush = 1'b1;
      #1;
      chk("flush_idle_stall", {63'd0, bus.o_stall}, 64'd0);
      @(negedge clk);
      bus.i_op_valid = 1'b0;
      bus.i_flush = 1'b0;
      #1;
      chk("flush_idle_busy", {63'd0, bus.o_busy}, 64'd0);

      for (int k = 0; k < 24; k++) begin
         rop = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         run_op(rop, ra, rb, 0);
      end

      // Asynchronous reset during divide iteration 5, op_valid still asserted
      @(negedge clk);
      bus.i_op_valid = 1'b1;
      bus.i_op = 3'd3;
      bus.i_src_a = 32'd1000;
      bus.i_src_b = 32'd3;
      for (int i = 1; i <= 5; i++) @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      m_hi = '0;
      m_lo = '0;
      chk("rst_mid_hilo", {bus.o_hi, bus.o_lo}, 64'd0);
      chk("rst_mid_stall_busy", {62'd0, bus.o_stall, bus.o_busy}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.i_op_valid = 1'b0;
      run_op(3'd5, 32'hDEAD_BEEF, 32'h1234_5678, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
